// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost scheduler.
//   dir_t          : pathfinder / move direction encoding
//   mode_t         : global ghost behaviour mode
//   sched_state_t  : sequencer state encoding
//   scatter_corner : fixed scatter target per ghost, packed {x[5:0], y[5:0]}
//   lfsr_next      : 8-bit LFSR step, taps 8,6,5,4
package ghost_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    SCATTER = 2'b00,
    CHASE   = 2'b01,
    FRIGHT  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StReq    = 2'b01,
    StCommit = 2'b10
  } sched_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Corners: ghost 0 top-right, 1 top-left, 2 bottom-right, 3 bottom-left.
  function automatic logic [11:0] scatter_corner(input logic [1:0] ghost);
    logic [11:0] corner;
    case (ghost)
      2'd0:    corner = {6'd27, 6'd0};
      2'd1:    corner = {6'd0,  6'd0};
      2'd2:    corner = {6'd27, 6'd35};
      default: corner = {6'd0,  6'd35};
    endcase
    return corner;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] lfsr);
    return {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  endfunction

endpackage

// File: rtl/ghost_mode_timer.sv
// Global mode timer: scatter/chase alternation, frightened entry on power pellets and
// restoration of the interrupted mode with its remaining count.
//   clk, reset      : clock, synchronous active-low reset
//   i_tick_acc      : game tick accepted by the sequencer (only while idle)
//   i_power_pellet  : pellet eaten strobe
//   o_mode          : registered current mode
//   o_mode_next     : mode that will be registered at the coming edge
module ghost_mode_timer
  import ghost_pkg::*;
#(
  parameter int unsigned SCATTER_TICKS = 7,
  parameter int unsigned CHASE_TICKS   = 20,
  parameter int unsigned FRIGHT_TICKS  = 6
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_tick_acc,
  input  logic  i_power_pellet,
  output mode_t o_mode,
  output mode_t o_mode_next
);

  localparam int unsigned MaxSc    = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
  localparam int unsigned MaxTicks = (MaxSc > FRIGHT_TICKS) ? MaxSc : FRIGHT_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);

  mode_t            r_mode, w_mode_d;
  mode_t            r_saved_mode, w_saved_mode_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [CntW-1:0]  r_saved_cnt, w_saved_cnt_d;

  // Pellet is applied first, then the tick acts on the resulting state, so a pellet
  // coincident with an accepted tick makes that round frightened.
  always_comb begin
    w_mode_d       = r_mode;
    w_cnt_d        = r_cnt;
    w_saved_mode_d = r_saved_mode;
    w_saved_cnt_d  = r_saved_cnt;

    if (i_power_pellet) begin
      if (r_mode != FRIGHT) begin
        w_saved_mode_d = r_mode;
        w_saved_cnt_d  = r_cnt;
      end
      w_mode_d = FRIGHT;
      w_cnt_d  = CntW'(FRIGHT_TICKS);
    end

    if (i_tick_acc) begin
      if (w_cnt_d == CntW'(1)) begin
        case (w_mode_d)
          SCATTER: begin
            w_mode_d = CHASE;
            w_cnt_d  = CntW'(CHASE_TICKS);
          end
          CHASE: begin
            w_mode_d = SCATTER;
            w_cnt_d  = CntW'(SCATTER_TICKS);
          end
          FRIGHT: begin
            w_mode_d = w_saved_mode_d;
            w_cnt_d  = w_saved_cnt_d;
          end
          default: begin
            w_mode_d = SCATTER;
            w_cnt_d  = CntW'(SCATTER_TICKS);
          end
        endcase
      end else begin
        w_cnt_d = w_cnt_d - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mode       <= SCATTER;
      r_cnt        <= CntW'(SCATTER_TICKS);
      r_saved_mode <= SCATTER;
      r_saved_cnt  <= CntW'(SCATTER_TICKS);
    end else begin
      r_mode       <= w_mode_d;
      r_cnt        <= w_cnt_d;
      r_saved_mode <= w_saved_mode_d;
      r_saved_cnt  <= w_saved_cnt_d;
    end
  end

  assign o_mode      = r_mode;
  assign o_mode_next = w_mode_d;

endmodule

// File: rtl/ghost_scheduler.sv
// Sequencer/arbiter for one shared ghost pathfinder. Each accepted game tick serves
// ghosts 0..NUM_GHOSTS-1 in order: latch a target by mode, handshake with the
// pathfinder (pfReq/pfAck), then emit one move command per ghost.
// Optional build macro: GHOST_SCHED_TIMEOUT_EN adds a REQ watchdog and pfTimeout output.
//   clk, reset              : clock, synchronous active-low reset
//   tick, powerPellet       : game-step strobe, pellet-eaten strobe
//   chaseTgtX/Y             : per-ghost chase targets, ghost i at [i*COORD_W +: COORD_W]
//   pfReq/pfGhost/pfTgtX/Y  : pathfinder request and its operands
//   pfAck/pfDir             : pathfinder result
//   moveValid/Ghost/Dir     : one-cycle move command
//   mode, busy, tickOverrun : current mode, round in progress, dropped-tick pulse
//   pfTimeout               : (optional) watchdog substituted the last direction
module ghost_scheduler
  import ghost_pkg::*;
#(
  parameter int unsigned NUM_GHOSTS    = 4,
  parameter int unsigned COORD_W       = 6,
  parameter int unsigned SCATTER_TICKS = 7,
  parameter int unsigned CHASE_TICKS   = 20,
  parameter int unsigned FRIGHT_TICKS  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          powerPellet,
  input  logic [NUM_GHOSTS*COORD_W-1:0] chaseTgtX,
  input  logic [NUM_GHOSTS*COORD_W-1:0] chaseTgtY,
  output logic                          pfReq,
  output logic [1:0]                    pfGhost,
  output logic [COORD_W-1:0]            pfTgtX,
  output logic [COORD_W-1:0]            pfTgtY,
  input  logic                          pfAck,
  input  logic [1:0]                    pfDir,
  output logic                          moveValid,
  output logic [1:0]                    moveGhost,
  output logic [1:0]                    moveDir,
  output logic [1:0]                    mode,
  output logic                          busy,
  output logic                          tickOverrun
`ifdef GHOST_SCHED_TIMEOUT_EN
  ,
  output logic                          pfTimeout
`endif
);

  sched_state_t        r_state, w_state_d;
  logic [1:0]          r_ghost, w_ghost_d;
  dir_t                r_dir, w_dir_d;
  logic [7:0]          r_lfsr;
  logic [COORD_W-1:0]  r_tgt_x, r_tgt_y, w_tgt_x, w_tgt_y;
  logic [11:0]         w_corner;
  logic                w_tick_acc;
  logic                w_enter_req;
  mode_t               w_mode, w_mode_next;

`ifdef GHOST_SCHED_TIMEOUT_EN
  // Fires at the end of the 15th REQ cycle without an ack.
  localparam logic [3:0] WdLast = 4'd14;
  logic [3:0] r_wd;
  dir_t       r_last_dir [NUM_GHOSTS];
  logic       r_timeout, w_timeout;
`endif

  assign w_tick_acc = tick && (r_state == StIdle);

  ghost_mode_timer #(
    .SCATTER_TICKS (SCATTER_TICKS),
    .CHASE_TICKS   (CHASE_TICKS),
    .FRIGHT_TICKS  (FRIGHT_TICKS)
  ) u_mode_timer (
    .clk            (clk),
    .reset          (reset),
    .i_tick_acc     (w_tick_acc),
    .i_power_pellet (powerPellet),
    .o_mode         (w_mode),
    .o_mode_next    (w_mode_next)
  );

  // Sequencer next state.
  always_comb begin
    w_state_d   = r_state;
    w_ghost_d   = r_ghost;
    w_dir_d     = r_dir;
    w_enter_req = 1'b0;
`ifdef GHOST_SCHED_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        if (tick) begin
          w_state_d   = StReq;
          w_ghost_d   = 2'd0;
          w_enter_req = 1'b1;
        end
      end
      StReq: begin
        if (pfAck) begin
          w_dir_d   = dir_t'(pfDir);
          w_state_d = StCommit;
        end
`ifdef GHOST_SCHED_TIMEOUT_EN
        else if (r_wd == WdLast) begin
          w_dir_d   = r_last_dir[r_ghost];
          w_state_d = StCommit;
          w_timeout = 1'b1;
        end
`endif
      end
      StCommit: begin
        if (r_ghost == 2'(NUM_GHOSTS - 1)) begin
          w_state_d = StIdle;
        end else begin
          w_ghost_d   = r_ghost + 2'd1;
          w_state_d   = StReq;
          w_enter_req = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Target for the ghost entering REQ, using the mode valid after this edge so a
  // pellet landing on the entry edge already affects that ghost.
  always_comb begin
    w_corner = scatter_corner(w_ghost_d);
    case (w_mode_next)
      SCATTER: begin
        w_tgt_x = COORD_W'(w_corner[11:6]);
        w_tgt_y = COORD_W'(w_corner[5:0]);
      end
      CHASE: begin
        w_tgt_x = chaseTgtX[w_ghost_d*COORD_W +: COORD_W];
        w_tgt_y = chaseTgtY[w_ghost_d*COORD_W +: COORD_W];
      end
      default: begin
        w_tgt_x = COORD_W'(r_lfsr[7:2]);
        w_tgt_y = COORD_W'(r_lfsr[5:0]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_ghost <= 2'd0;
      r_dir   <= UP;
      r_lfsr  <= LFSR_SEED;
      r_tgt_x <= '0;
      r_tgt_y <= '0;
    end else begin
      r_state <= w_state_d;
      r_ghost <= w_ghost_d;
      r_dir   <= w_dir_d;
      if (w_enter_req) begin
        r_tgt_x <= w_tgt_x;
        r_tgt_y <= w_tgt_y;
        r_lfsr  <= lfsr_next(r_lfsr);
      end
    end
  end

`ifdef GHOST_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
      for (int i = 0; i < int'(NUM_GHOSTS); i++) r_last_dir[i] <= UP;
    end else begin
      r_timeout <= w_timeout;
      if (w_enter_req) begin
        r_wd <= '0;
      end else if (r_state == StReq) begin
        r_wd <= r_wd + 4'd1;
      end
      if (r_state == StCommit) r_last_dir[r_ghost] <= r_dir;
    end
  end

  assign pfTimeout = r_timeout;
`endif

  assign pfReq       = (r_state == StReq);
  assign busy        = (r_state != StIdle);
  assign moveValid   = (r_state == StCommit);
  assign pfGhost     = r_ghost;
  assign moveGhost   = r_ghost;
  assign moveDir     = r_dir;
  assign pfTgtX      = r_tgt_x;
  assign pfTgtY      = r_tgt_y;
  assign mode        = w_mode;
  assign tickOverrun = tick && busy;

endmodule
